// File: rtl/field_adder_arb_pkg.sv
// ============================================================================
//  Module      : field_adder_arb_pkg
//  Description : Shared types, limits and helpers for the field adder arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_ADD_CYCLES
`define F_ADD_CYCLES 3
`endif
`ifndef F_PRIME
`define F_PRIME 65521
`endif

package field_adder_arb_pkg;

    localparam int ARB_MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Index width for sel/ptr; never below one bit so n_req=1 still has a port.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/field_adder.sv
// ============================================================================
//  Module      : field_adder
//  Description : Modular adder (a+b) mod p; ready_pulse n_cyc+1 cycles after en.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_adder #(
    parameter int n_cyc = `F_ADD_CYCLES
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic [`F_NBITS-1:0] a,
    input  logic [`F_NBITS-1:0] b,
    output logic [`F_NBITS-1:0] c,
    output logic                ready_pulse
);

    localparam int NB = `F_NBITS;
    localparam logic [NB:0] c_p = (NB+1)'(`F_PRIME);

    logic [NB:0]    w_sum;
    logic [NB-1:0]  c_q, c_d;
    logic [n_cyc:0] vld_q, vld_d;

    // Operands are assumed already reduced below p, so one conditional subtract suffices.
    always_comb begin
        w_sum = {1'b0, a} + {1'b0, b};
        c_d   = c_q;
        if (en) begin
            c_d = (w_sum >= c_p) ? NB'(w_sum - c_p) : NB'(w_sum);
        end
        vld_d = (n_cyc+1)'({vld_q, en});
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_q   <= '0;
            vld_q <= '0;
        end else begin
            c_q   <= c_d;
            vld_q <= vld_d;
        end
    end

    assign c           = c_q;
    assign ready_pulse = vld_q[n_cyc];

endmodule

`default_nettype wire

// File: rtl/field_adder_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner: first set req at/after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import field_adder_arb_pkg::*;
#(
    parameter int n_req = 4,
    parameter int SEL_W = clog2(n_req)
) (
    input  logic [n_req-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             vld
);

    localparam logic [SEL_W:0] c_nreq = (SEL_W+1)'(n_req);

    logic [n_req-1:0] w_rot;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W:0]   w_sum;

    // Rotate so that bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        w_rot = n_req'({req, req} >> ptr);
        w_off = '0;
        for (int k = n_req - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = SEL_W'(k);
        end
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= c_nreq) w_sum = w_sum - c_nreq;
        win = w_sum[SEL_W-1:0];
        vld = |req;
    end

endmodule

`default_nettype wire

// File: rtl/field_adder_arbiter.sv
// ============================================================================
//  Module      : field_adder_arbiter
//  Description : Round-robin sharing of one field_adder among n_req requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module field_adder_arbiter
    import field_adder_arb_pkg::*;
#(
    parameter int n_req = 4,
    parameter int n_cyc = `F_ADD_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_req-1:0]          req,
    input  logic [n_req*`F_NBITS-1:0] a,
    input  logic [n_req*`F_NBITS-1:0] b,
    output logic [n_req-1:0]          gnt,
    output logic [n_req-1:0]          done,
    output logic [`F_NBITS-1:0]       c,
    output logic                      busy
);

    localparam int NB    = `F_NBITS;
    localparam int SEL_W = clog2(n_req);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [NB-1:0]    opa_q, opa_d;
    logic [NB-1:0]    opb_q, opb_d;
    logic [NB-1:0]    c_q, c_d;
    logic [n_req-1:0] gnt_q, gnt_d;
    logic [n_req-1:0] done_q, done_d;

    logic [SEL_W-1:0] w_win;
    logic             w_vld;
    logic             w_en;
    logic [NB-1:0]    w_add_c;
    logic             w_add_rdy;

    rr_pick #(
        .n_req (n_req),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (w_win),
        .vld (w_vld)
    );

    assign w_en = (state_q == ISSUE);

    field_adder #(
        .n_cyc (n_cyc)
    ) u_field_adder (
        .clk         (clk),
        .rstb        (~rst),
        .en          (w_en),
        .a           (opa_q),
        .b           (opb_q),
        .c           (w_add_c),
        .ready_pulse (w_add_rdy)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        c_d     = c_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (w_vld) begin
                    sel_d        = w_win;
                    opa_d        = a[int'(w_win)*NB +: NB];
                    opb_d        = b[int'(w_win)*NB +: NB];
                    gnt_d[w_win] = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (w_add_rdy) begin
                    c_d          = w_add_c;
                    done_d[sel_q] = 1'b1;
                    ptr_d        = (sel_q == SEL_W'(n_req - 1)) ? '0 : sel_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            c_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            c_q     <= c_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign c    = c_q;
    assign busy = (state_q != IDLE);

`ifndef SYNTHESIS
    a_gnt_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(done_q));
    a_en_issue:    assert property (@(posedge clk) disable iff (rst) w_en |-> (state_q == ISSUE));
    a_rdy_wait:    assert property (@(posedge clk) disable iff (rst) w_add_rdy |-> (state_q == WAIT));
`endif

endmodule

`default_nettype wire
